cs_microsequencer: RTL
======================

# cs_microsequencer

Parametrised control-store microsequencer for the microprogrammed datapath. It holds the registered micro-program counter (uPC) and selects the next control-store address from increment, absolute jump, opcode decode map, flag-conditional jump, or subroutine call/return. Subroutine calls use a bounded return-address stack. Its output drives the control-store ROM address each cycle.

## Interface
Parameters:
- ADDR_WIDTH, 11, control-store address width
- DECODE_WIDTH, 8, opcode field width; elaboration error unless ADDR_WIDTH >= DECODE_WIDTH+3
- STACK_DEPTH, 4, return-address stack entries (>=1)
- COND_WIDTH, 4, number of condition flags (>=2)
- RESET_ADDR, 0, uPC value after reset

Ports:
- CS_uSequencer_CLOCK_50  in  1  single clock, rising edge
- CS_uSequencer_RESET_InLow  in  1  asynchronous, active-low reset
- CS_uSequencer_Enable_IN  in  1  advance when 1; full hold when 0
- CS_uSequencer_Op_IN  in  3  sequencing operation (see Operation)
- CS_uSequencer_Jump_IN  in  ADDR_WIDTH  branch/call target
- CS_uSequencer_Decode_IN  in  DECODE_WIDTH  macro-instruction opcode
- CS_uSequencer_CondSel_IN  in  $clog2(COND_WIDTH)  flag index
- CS_uSequencer_Flags_IN  in  COND_WIDTH  datapath status flags
- CS_uSequencer_Address_OUT  out  ADDR_WIDTH  current uPC (registered)
- CS_uSequencer_StackDepth_OUT  out  $clog2(STACK_DEPTH+1)  occupied entries
- CS_uSequencer_Error_OUT  out  1  sticky stack overflow/underflow

## Operation
- Reset: Address_OUT = RESET_ADDR, StackDepth_OUT = 0, Error_OUT = 0, stack contents don't-care.
- NEXT = uPC+1, modulo 2^ADDR_WIDTH (wrap all-ones -> 0). Op codes, evaluated when Enable_IN=1:
  - 000 NEXT: uPC <= NEXT
  - 001 JUMP: uPC <= Jump_IN
  - 010 DECODE: uPC <= {1'b1, zeros, Decode_IN, 2'b00}; MSB set, Decode_IN at bits [DECODE_WIDTH+1:2], bits [1:0]=0, gap bits 0
  - 011 CJUMP: uPC <= Flags_IN[CondSel_IN] ? Jump_IN : NEXT
  - 100 CALL: push NEXT, uPC <= Jump_IN
  - 101 RET: pop, uPC <= popped value
  - 110 CJUMPN: uPC <= Flags_IN[CondSel_IN] ? NEXT : Jump_IN
  - 111 HOLD: uPC unchanged
- CondSel_IN >= COND_WIDTH: selected flag reads 0.
- CALL with stack full: no push, uPC <= NEXT, Error_OUT <= 1.
- RET with stack empty: no pop, uPC <= NEXT, Error_OUT <= 1.
- Error_OUT sticky; clears only on reset.
- Enable_IN=0: uPC, stack, depth, Error_OUT all hold regardless of Op_IN.

## Timing
- All outputs registered; no combinational input->output path.
- Op sampled at edge N; new Address_OUT and StackDepth_OUT visible after edge N; control-store read of that address occurs in cycle N+1.
- Back-to-back CALL/RET each cycle supported; RET immediately after CALL returns the just-pushed NEXT.
- Reset assertion mid-operation: outputs reach reset values asynchronously, independent of clock; deassertion is synchronised externally.

## Configuration
- CS_USEQ_STACK_EN defined: stack, CALL/RET, overflow/underflow detection as above.
- Not defined: no stack storage; CALL behaves as JUMP (no push), RET behaves as NEXT, StackDepth_OUT tied 0, Error_OUT tied 0.

## Structure
- Shared package cs_useq_pkg: op-code constants (OP_NEXT..OP_HOLD), op width (3), decode-map function.
- One sub-module cs_useq_stack: LIFO of STACK_DEPTH x ADDR_WIDTH with push/pop, full/empty, depth count; instantiated only under CS_USEQ_STACK_EN.

## Test plan
- Reset then 3 cycles NEXT -> Address_OUT 0,1,2,3; force uPC 0x7FF via JUMP then NEXT -> 0x000.
- DECODE with Decode_IN=0xA5 (defaults) -> Address_OUT=0x694.
- CJUMP CondSel=2, Flags=0b0100, Jump=0x123 -> 0x123; Flags=0 -> uPC+1; CJUMPN inverse.
- From 0x010, CALL 0x200 -> 0x200, depth 1; RET -> 0x011, depth 0.
- 5 nested CALLs (depth 4) -> 5th yields NEXT, Error_OUT=1, depth 4; 4 RETs unwind in order; 5th RET -> NEXT, Error stays 1.
- Enable_IN=0 with Op=JUMP -> no change; reset asserted mid-CALL sequence -> Address=RESET_ADDR, depth 0, Error 0 immediately.

Source files
------------

// File: rtl/cs_useq_pkg.sv
// Shared definitions for the control-store microsequencer: op codes and the
// opcode decode-map function.
package cs_useq_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NEXT   = 3'b000,
    OP_JUMP   = 3'b001,
    OP_DECODE = 3'b010,
    OP_CJUMP  = 3'b011,
    OP_CALL   = 3'b100,
    OP_RET    = 3'b101,
    OP_CJUMPN = 3'b110,
    OP_HOLD   = 3'b111
  } op_e;

  // Opcode lands at bits [w+1:2], the address MSB marks the decode region.
  function automatic logic [31:0] decode_map(input logic [31:0] opcode,
                                             input int unsigned addr_width);
    logic [31:0] map_s;
    map_s = opcode << 5'd2;
    map_s = map_s | (32'd1 << (addr_width - 32'd1));
    return map_s;
  endfunction

endpackage

// File: rtl/cs_useq_stack.sv
// Return-address LIFO for the microsequencer: push/pop with full/empty flags
// and an occupancy count. Pushes when full and pops when empty are ignored.
module cs_useq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int DW    = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [DW-1:0]    depth_r;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] rd_idx_s;

  assign wr_idx_s = IDX_W'(depth_r);
  assign rd_idx_s = IDX_W'(depth_r - DW'(1));
  assign full     = (depth_r == DW'(DEPTH));
  assign empty    = (depth_r == DW'(0));
  assign depth    = depth_r;
  assign top_data = mem_r[rd_idx_s];

  // Storage and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_r <= DW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push && !full) begin
      mem_r[wr_idx_s] <= push_data;
      depth_r         <= depth_r + DW'(1);
    end else if (pop && !empty) begin
      depth_r <= depth_r - DW'(1);
    end else begin
      depth_r <= depth_r;
    end
  end

endmodule

// File: rtl/cs_microsequencer.sv
// Control-store microsequencer: registered uPC with next/jump/decode/conditional
// and call/return sequencing. Return stack built only with CS_USEQ_STACK_EN.
module cs_microsequencer
  import cs_useq_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 11,
  parameter int          DECODE_WIDTH = 8,
  parameter int          STACK_DEPTH  = 4,
  parameter int          COND_WIDTH   = 4,
  parameter int unsigned RESET_ADDR   = 32'd0
) (
  input  logic                               CS_uSequencer_CLOCK_50,
  input  logic                               CS_uSequencer_RESET_InLow,
  input  logic                               CS_uSequencer_Enable_IN,
  input  logic [OP_WIDTH-1:0]                CS_uSequencer_Op_IN,
  input  logic [ADDR_WIDTH-1:0]              CS_uSequencer_Jump_IN,
  input  logic [DECODE_WIDTH-1:0]            CS_uSequencer_Decode_IN,
  input  logic [$clog2(COND_WIDTH)-1:0]      CS_uSequencer_CondSel_IN,
  input  logic [COND_WIDTH-1:0]              CS_uSequencer_Flags_IN,
  output logic [ADDR_WIDTH-1:0]              CS_uSequencer_Address_OUT,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   CS_uSequencer_StackDepth_OUT,
  output logic                               CS_uSequencer_Error_OUT
);

  localparam int CSEL_W  = $clog2(COND_WIDTH);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [CSEL_W:0] COND_LIMIT = (CSEL_W + 1)'(COND_WIDTH);

  if (ADDR_WIDTH < DECODE_WIDTH + 3) begin : g_bad_addr_width
    $error("cs_microsequencer: ADDR_WIDTH must be >= DECODE_WIDTH+3");
  end
  if (ADDR_WIDTH > 32) begin : g_wide_addr
    $error("cs_microsequencer: ADDR_WIDTH above 32 not supported");
  end
  if (STACK_DEPTH < 1 || COND_WIDTH < 2) begin : g_bad_sizes
    $error("cs_microsequencer: STACK_DEPTH >= 1 and COND_WIDTH >= 2 required");
  end

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] addr_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_inc_s;
  logic [ADDR_WIDTH-1:0] decode_addr_s;
  logic                  flag_sel_s;

  assign addr_inc_s    = addr_r + ADDR_WIDTH'(1);
  assign decode_addr_s = ADDR_WIDTH'(decode_map(32'(CS_uSequencer_Decode_IN), ADDR_WIDTH));
  // Out-of-range flag selects read as a cleared flag.
  assign flag_sel_s    = ({1'b0, CS_uSequencer_CondSel_IN} < COND_LIMIT) ?
                         CS_uSequencer_Flags_IN[CS_uSequencer_CondSel_IN] : 1'b0;

`ifdef CS_USEQ_STACK_EN
  logic                  push_s;
  logic                  pop_s;
  logic                  err_set_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  err_r;
  logic [ADDR_WIDTH-1:0] top_s;
  logic [DEPTH_W-1:0]    depth_s;

  cs_useq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stack (
    .clk       (CS_uSequencer_CLOCK_50),
    .rst_n     (CS_uSequencer_RESET_InLow),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (addr_inc_s),
    .top_data  (top_s),
    .full      (full_s),
    .empty     (empty_s),
    .depth     (depth_s)
  );

  assign CS_uSequencer_StackDepth_OUT = depth_s;
  assign CS_uSequencer_Error_OUT      = err_r;
`else
  assign CS_uSequencer_StackDepth_OUT = DEPTH_W'(0);
  assign CS_uSequencer_Error_OUT      = 1'b0;
`endif

  // Next-address selection and stack requests.
  always_comb begin
    addr_nxt_s = addr_r;
`ifdef CS_USEQ_STACK_EN
    push_s     = 1'b0;
    pop_s      = 1'b0;
    err_set_s  = 1'b0;
`endif
    if (CS_uSequencer_Enable_IN) begin
      case (op_e'(CS_uSequencer_Op_IN))
        OP_NEXT:   addr_nxt_s = addr_inc_s;
        OP_JUMP:   addr_nxt_s = CS_uSequencer_Jump_IN;
        OP_DECODE: addr_nxt_s = decode_addr_s;
        OP_CJUMP:  addr_nxt_s = flag_sel_s ? CS_uSequencer_Jump_IN : addr_inc_s;
        OP_CJUMPN: addr_nxt_s = flag_sel_s ? addr_inc_s : CS_uSequencer_Jump_IN;
        OP_CALL: begin
`ifdef CS_USEQ_STACK_EN
          if (full_s) begin
            addr_nxt_s = addr_inc_s;
            err_set_s  = 1'b1;
          end else begin
            push_s     = 1'b1;
            addr_nxt_s = CS_uSequencer_Jump_IN;
          end
`else
          addr_nxt_s = CS_uSequencer_Jump_IN;
`endif
        end
        OP_RET: begin
`ifdef CS_USEQ_STACK_EN
          if (empty_s) begin
            addr_nxt_s = addr_inc_s;
            err_set_s  = 1'b1;
          end else begin
            pop_s      = 1'b1;
            addr_nxt_s = top_s;
          end
`else
          addr_nxt_s = addr_inc_s;
`endif
        end
        OP_HOLD:   addr_nxt_s = addr_r;
        default:   addr_nxt_s = addr_r;
      endcase
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // uPC register.
  always_ff @(posedge CS_uSequencer_CLOCK_50 or negedge CS_uSequencer_RESET_InLow) begin
    if (!CS_uSequencer_RESET_InLow) begin
      addr_r <= ADDR_WIDTH'(RESET_ADDR);
    end else begin
      addr_r <= addr_nxt_s;
    end
  end

`ifdef CS_USEQ_STACK_EN
  // Sticky overflow/underflow flag.
  always_ff @(posedge CS_uSequencer_CLOCK_50 or negedge CS_uSequencer_RESET_InLow) begin
    if (!CS_uSequencer_RESET_InLow) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end
`endif

  assign CS_uSequencer_Address_OUT = addr_r;

endmodule
